i2s_to_pcm_rj: RTL and testbench
================================

I2S_TO_PCM_RJ -- requirements
Module: i2s_to_pcm_rj

Interface
REQ-001 DATA_BITS, 24, output word width per channel; legal range 16..24.
REQ-002 SLOT_BITS, 32, BCK cycles per I2S half-frame; legal range DATA_BITS+1..32.
REQ-003 LOCK_FRAMES, 4, consecutive good stereo frames required to declare lock; legal range 1..15.
REQ-004 BCK  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 LRCK  in  1  I2S word select; 0 = left, 1 = right.
REQ-007 DATAIN  in  1  I2S serial data, MSB first, one-bit delayed.
REQ-008 MUTE_IN  in  1  soft mute request.
REQ-009 CLKOUT  out  1  DAC bit clock, equal to inverted BCK (combinational).
REQ-010 DATAOUTL / DATAOUTR  out  1 each  right-justified serial data per channel.
REQ-011 LEOUT  out  1  shared DAC latch enable.
REQ-012 LOCKED  out  1  frame lock indicator.

Function
REQ-013 LRCK SHALL be registered into lrck_q every cycle; edge cycle E is any cycle with LRCK != lrck_q.
REQ-014 DATAIN in cycles E+1..E+DATA_BITS SHALL be shifted MSB-first into the left capture register (LRCK=0) or right capture register (LRCK=1); slot bits beyond DATA_BITS SHALL be ignored.
REQ-015 A slot counter SHALL restart at 0 in every E; a half-frame is good when the next edge arrives with counter == SLOT_BITS-1, bad when early or when the counter reaches SLOT_BITS without an edge (saturate, no wrap).
REQ-016 Lock FSM states: UNLOCKED, ACQUIRE, LOCKED.
REQ-017 UNLOCKED->ACQUIRE on first edge; ACQUIRE->LOCKED after 2*LOCK_FRAMES consecutive good half-frames; a bad half-frame in ACQUIRE SHALL clear the good count; any bad half-frame in LOCKED SHALL go to ACQUIRE with count 0.
REQ-018 LOCKED SHALL be 1 only in state LOCKED.
REQ-019 Load cycle F is a falling LRCK edge (end of right half-frame); in F both capture registers SHALL transfer to the output shifters, replaced by zero if MUTE_IN=1 or the state is not LOCKED in F.
REQ-020 Bit k of the loaded word (k=DATA_BITS-1 is MSB) SHALL drive DATAOUTx in cycle F+1+(2*SLOT_BITS-DATA_BITS)+(DATA_BITS-1-k); outside that window DATAOUTx SHALL be 0.
REQ-021 LEOUT SHALL be 0 exactly during the data window and 1 otherwise; its rising edge in cycle F+1+2*SLOT_BITS latches the word.
REQ-022 Both channels SHALL be output simultaneously on the same LEOUT edge; input-to-latch latency is exactly 2*SLOT_BITS+1 cycles after F.
REQ-023 On leaving LOCKED, the output shifters SHALL be zeroed in the next cycle and LEOUT held 1 until the first load after re-lock.
REQ-024 MUTE_IN changes SHALL take effect only at the next F (no mid-word truncation).
REQ-025 An edge coinciding with saturation of the slot counter SHALL count as bad.

Reset
REQ-026 While reset=1: state UNLOCKED, counters 0, capture/output registers 0, lrck_q 0, DATAOUTL=DATAOUTR=0, LEOUT=1, LOCKED=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; first capture after release starts at the next edge.

Structure
REQ-028 Lock state encoding and default parameter constants SHALL live in shared package i2s_dac_pkg.
REQ-029 The lock FSM with slot counter SHALL be a sub-module i2s_frame_lock; capture, load and output shifting remain in the top module.

Verification (DATA_BITS=24, SLOT_BITS=32, LOCK_FRAMES=4)
REQ-030 Reset then 8 good half-frames -> LOCKED rises in the cycle after the 8th good edge; DATAOUTx 0 throughout.
REQ-031 Locked, L=0x800001, R=0x7FFFFE -> DATAOUTL/R MSB at F+41, LSB at F+64, LEOUT low F+41..F+64, high at F+65.
REQ-032 Locked, one half-frame of 31 cycles -> LOCKED falls, outputs zero next cycle, re-lock after 8 good half-frames.
REQ-033 MUTE_IN asserted mid-serialisation of L=0x123456 -> current word completes unchanged, next frame outputs 0x000000.
REQ-034 reset pulsed for 1 cycle mid-word -> all outputs at reset values next cycle, LOCKED=0, capture resumes at next LRCK edge.
REQ-035 LRCK held constant for 40 cycles -> bad half-frame at saturation, state ACQUIRE, LOCKED=0.

Source files
------------

// File: rtl/i2s_dac_pkg.sv
// Shared definitions for the I2S receiver / right-justified DAC formatter:
// lock-state encoding, default geometry and a counter-width helper.
package i2s_dac_pkg;

  localparam int DEF_DATA_BITS   = 24;
  localparam int DEF_SLOT_BITS   = 32;
  localparam int DEF_LOCK_FRAMES = 4;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2s_frame_lock.sv
// LRCK edge detector, saturating slot counter and frame-lock state machine.
// Judges every half-frame as good (exactly SLOT_BITS long) or bad.
module i2s_frame_lock
  import i2s_dac_pkg::*;
#(
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
  localparam int CW         = cnt_width(SLOT_BITS)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          lrck_in,
  output logic          lrck_dly,
  output logic          lrck_edge,
  output logic [CW-1:0] slot_cnt,
  output logic          locked,
  output logic          lose_lock
);

  localparam int GW = cnt_width(2 * LOCK_FRAMES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(SLOT_BITS);
  localparam logic [GW-1:0] GOOD_LAST = GW'(2 * LOCK_FRAMES - 1);

  logic          lrck_q, lrck_d;
  logic [CW-1:0] cnt_q, cnt_d;
  lock_state_e   state_q;
  logic [GW-1:0] good_q;
  logic          locked_q;
  logic          hf_good, hf_bad;

  assign lrck_edge = lrck_in ^ lrck_q;
  assign hf_good   = lrck_edge && (cnt_q == CNT_LAST);
  // Early edges, edges after saturation and a missing edge are all bad.
  assign hf_bad    = lrck_edge ? (cnt_q != CNT_LAST) : (cnt_q == CNT_LAST);

  always_comb begin
    lrck_d = lrck_in;
    cnt_d  = cnt_q;
    if (lrck_edge) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      lrck_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lrck_q <= lrck_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= ST_UNLOCKED;
      good_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        ST_UNLOCKED: begin
          if (lrck_edge) begin
            state_q <= ST_ACQUIRE;
            good_q  <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (hf_bad) begin
            good_q <= '0;
          end else if (hf_good) begin
            if (good_q == GOOD_LAST) begin
              state_q  <= ST_LOCKED;
              good_q   <= '0;
              locked_q <= 1'b1;
            end else begin
              good_q <= good_q + GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (hf_bad) begin
            state_q  <= ST_ACQUIRE;
            good_q   <= '0;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_UNLOCKED;
          good_q   <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign lrck_dly  = lrck_q;
  assign slot_cnt  = cnt_q;
  assign locked    = locked_q;
  assign lose_lock = (state_q == ST_LOCKED) && hf_bad;

endmodule

// File: rtl/i2s_to_pcm_rj.sv
// I2S receiver re-serialising both channels as right-justified words that
// end exactly on a shared latch-enable rising edge, 2*SLOT_BITS+1 after load.
module i2s_to_pcm_rj
  import i2s_dac_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic BCK,
  input  logic reset,
  input  logic LRCK,
  input  logic DATAIN,
  input  logic MUTE_IN,
  output logic CLKOUT,
  output logic DATAOUTL,
  output logic DATAOUTR,
  output logic LEOUT,
  output logic LOCKED
);

  localparam int CW   = cnt_width(SLOT_BITS);
  localparam int TMAX = 2 * SLOT_BITS + 1;
  localparam int TW   = cnt_width(TMAX);
  localparam logic [CW-1:0] CAP_BITS  = CW'(DATA_BITS);
  localparam logic [TW-1:0] WIN_FIRST = TW'(2 * SLOT_BITS - DATA_BITS + 1);
  localparam logic [TW-1:0] WIN_LAST  = TW'(2 * SLOT_BITS);
  localparam logic [TW-1:0] T_SAT     = TW'(TMAX);

  logic          lrck_dly, lrck_edge, lose_lock;
  logic [CW-1:0] slot_cnt;

  i2s_frame_lock #(
    .SLOT_BITS   (SLOT_BITS),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_lock (
    .clk       (BCK),
    .srst      (reset),
    .lrck_in   (LRCK),
    .lrck_dly  (lrck_dly),
    .lrck_edge (lrck_edge),
    .slot_cnt  (slot_cnt),
    .locked    (LOCKED),
    .lose_lock (lose_lock)
  );

  logic          cap_act_q, cap_act_d;
  logic [TW-1:0] tc_q, tc_d;
  logic          out_act_q, out_act_d;
  logic          le_q, le_d;
  logic          load_f, keep_word, shift_en, win;
  logic [1:0]    dout_bus;

  assign load_f    = lrck_edge && !LRCK;
  assign keep_word = LOCKED && !MUTE_IN;
  // cap_act stops a fresh reset from capturing before the first real edge.
  assign shift_en  = cap_act_q && !lrck_edge && (slot_cnt < CAP_BITS);

  always_comb begin
    cap_act_d = cap_act_q | lrck_edge;
    tc_d      = tc_q;
    if (load_f) begin
      tc_d = TW'(1);
    end else if (tc_q != T_SAT) begin
      tc_d = tc_q + TW'(1);
    end
  end

  assign win = out_act_q && (tc_d >= WIN_FIRST) && (tc_d <= WIN_LAST);

  always_comb begin
    out_act_d = out_act_q;
    le_d      = !win;
    if (lose_lock) begin
      out_act_d = 1'b0;
      le_d      = 1'b1;
    end else if (load_f) begin
      out_act_d = LOCKED;
    end
  end

  always_ff @(posedge BCK) begin
    if (reset) begin
      cap_act_q <= 1'b0;
      tc_q      <= '0;
      out_act_q <= 1'b0;
      le_q      <= 1'b1;
    end else begin
      cap_act_q <= cap_act_d;
      tc_q      <= tc_d;
      out_act_q <= out_act_d;
      le_q      <= le_d;
    end
  end

  // Channel 0 captures while LRCK is low (left), channel 1 while high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    localparam logic CH = 1'(gi);

    logic [DATA_BITS-1:0] cap_q, cap_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 dout_q, dout_d;

    always_comb begin
      cap_d  = cap_q;
      sh_d   = sh_q;
      dout_d = 1'b0;
      if (shift_en && (lrck_dly == CH)) begin
        cap_d = {cap_q[DATA_BITS-2:0], DATAIN};
      end
      if (lose_lock) begin
        sh_d = '0;
      end else if (load_f) begin
        sh_d = keep_word ? cap_q : '0;
      end else if (win) begin
        dout_d = sh_q[DATA_BITS-1];
        sh_d   = {sh_q[DATA_BITS-2:0], 1'b0};
      end
    end

    always_ff @(posedge BCK) begin
      if (reset) begin
        cap_q  <= '0;
        sh_q   <= '0;
        dout_q <= 1'b0;
      end else begin
        cap_q  <= cap_d;
        sh_q   <= sh_d;
        dout_q <= dout_d;
      end
    end

    assign dout_bus[gi] = dout_q;
  end

  assign CLKOUT   = ~BCK;
  assign DATAOUTL = dout_bus[0];
  assign DATAOUTR = dout_bus[1];
  assign LEOUT    = le_q;

endmodule

// File: tb/tb_i2s_to_pcm_rj.sv
// Randomised I2S frames against a cycle-numbered reference model; expected
// words and lock levels go to queues that a negedge monitor drains.
module tb_i2s_to_pcm_rj;

  localparam int DB  = 24;
  localparam int SB  = 32;
  localparam int LF  = 4;
  localparam int LAT = 2 * SB + 1;

  logic BCK = 1'b0;
  logic reset = 1'b1;
  logic LRCK = 1'b0;
  logic DATAIN = 1'b0;
  logic MUTE_IN = 1'b0;
  logic CLKOUT, DATAOUTL, DATAOUTR, LEOUT, LOCKED;

  i2s_to_pcm_rj #(
    .DATA_BITS   (DB),
    .SLOT_BITS   (SB),
    .LOCK_FRAMES (LF)
  ) dut (
    .BCK      (BCK),
    .reset    (reset),
    .LRCK     (LRCK),
    .DATAIN   (DATAIN),
    .MUTE_IN  (MUTE_IN),
    .CLKOUT   (CLKOUT),
    .DATAOUTL (DATAOUTL),
    .DATAOUTR (DATAOUTR),
    .LEOUT    (LEOUT),
    .LOCKED   (LOCKED)
  );

  always #5 BCK = ~BCK;

  int unsigned cyc = 0;
  always @(posedge BCK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned   due;
    logic [DB-1:0] l;
    logic [DB-1:0] r;
  } word_t;

  typedef struct {
    int unsigned c;
    bit          locked;
    bit          rst_chk;
  } lock_t;

  word_t exp_q[$];
  lock_t lock_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state: lock judged from half-frame lengths in cycles.
  bit            m_prev = 1'b0;
  int            m_state = 0;          // 0 unlocked, 1 acquiring, 2 locked
  int            m_run = 0;
  int unsigned   m_last_edge = 0;
  bit            m_rst_prev = 1'b1;
  bit            m_mute = 1'b0;
  logic [DB-1:0] m_left = '0;
  logic [DB-1:0] m_right = '0;

  task automatic drop_after(input int unsigned lim);
    while (exp_q.size() > 0 && exp_q[$].due > lim) void'(exp_q.pop_back());
  endtask

  task automatic model_cycle(input bit v, input bit rst);
    bit edge_s, good, bad, was_locked;
    if (rst) begin
      m_prev  = 1'b0;
      m_state = 0;
      m_run   = 0;
      drop_after(cyc);
      return;
    end
    edge_s     = (v != m_prev);
    m_prev     = v;
    was_locked = (m_state == 2);
    if (m_state == 0) begin
      if (edge_s) begin
        m_state     = 1;
        m_run       = 0;
        m_last_edge = cyc;
      end
      return;
    end
    good = 1'b0;
    bad  = 1'b0;
    if (edge_s) begin
      good        = ((cyc - m_last_edge) == SB);
      bad         = !good;
      m_last_edge = cyc;
    end else if ((cyc - m_last_edge) == SB) begin
      bad = 1'b1;
    end
    if (edge_s && !v && was_locked && good)
      exp_q.push_back('{cyc + LAT, MUTE_IN ? '0 : m_left, MUTE_IN ? '0 : m_right});
    if (good && m_state == 1) begin
      m_run++;
      if (m_run == 2 * LF) m_state = 2;
    end
    if (bad) begin
      if (m_state == 2) drop_after(cyc + 1);
      m_state = 1;
      m_run   = 0;
    end
  endtask

  task automatic step(input bit v, input bit d, input bit rst);
    @(posedge BCK);
    #1;
    lock_q.push_back('{cyc, (m_state == 2), m_rst_prev});
    LRCK    = v;
    DATAIN  = d;
    reset   = rst;
    MUTE_IN = m_mute;
    model_cycle(v, rst);
    m_rst_prev = rst;
  endtask

  task automatic drive_half(input bit v, input int len, input logic [DB-1:0] word,
                            input int rst_at, input int mute_at, input bit mute_val);
    bit d;
    for (int i = 0; i < len; i++) begin
      if (i == mute_at) m_mute = mute_val;
      d = (i >= 1 && i <= DB) ? word[DB-i] : 1'($urandom);
      step(v, d, i == rst_at);
    end
    if (v) m_right = word;
    else   m_left  = word;
  endtask

  // Monitor: assembles serial words while LEOUT is low, checks on its rise.
  lock_t         cur_l;
  word_t         cur_w;
  bit            rst_now;
  logic          prev_le = 1'b1;
  int            bits = 0;
  logic [DB-1:0] wl = '0, wr = '0;

  initial begin
    forever begin
      @(negedge BCK);
      rst_now = 1'b0;
      if (lock_q.size() > 0 && lock_q[0].c == cyc) begin
        cur_l = lock_q.pop_front();
        check("locked", 32'(LOCKED), 32'(cur_l.locked));
        if (cur_l.rst_chk) begin
          rst_now = 1'b1;
          check("reset_leout", 32'(LEOUT), 32'd1);
          check("reset_dataout", {30'd0, DATAOUTL, DATAOUTR}, 32'd0);
        end
      end
      if (LEOUT === 1'b0) begin
        if (prev_le) bits = 0;
        wl = {wl[DB-2:0], DATAOUTL};
        wr = {wr[DB-2:0], DATAOUTR};
        bits++;
      end else begin
        check("idle_zero", {30'd0, DATAOUTL, DATAOUTR}, 32'd0);
        if (prev_le === 1'b0 && !rst_now) begin
          check("latch_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            cur_w = exp_q.pop_front();
            $display("latch cycle %0d: L=%06h R=%06h bits=%0d", cyc, wl, wr, bits);
            check("latch_cycle", cyc, cur_w.due);
            check("window_bits", bits, DB);
            check("word_left", 32'(wl), 32'(cur_w.l));
            check("word_right", 32'(wr), 32'(cur_w.r));
          end
        end
      end
      prev_le = LEOUT;
    end
  end

  initial begin
    logic [DB-1:0] wl_s, wr_s;
    int            len_l, k, r_rst, r_mute_at, l_mute_at;
    bit            r_mute_val, l_mute_val;

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);

    for (int f = 0; f < 60; f++) begin
      wl_s       = DB'($urandom);
      wr_s       = DB'($urandom);
      len_l      = SB;
      r_rst      = -1;
      l_mute_at  = -1;
      r_mute_at  = -1;
      l_mute_val = m_mute;
      r_mute_val = m_mute;
      if (f == 12) begin
        wl_s = 24'h800001;
        wr_s = 24'h7FFFFE;
      end else if (f == 20) begin
        wl_s = 24'h123456;
      end else if (f == 21) begin
        r_mute_at  = 15;
        r_mute_val = 1'b1;
      end else if (f == 22) begin
        r_mute_at  = 3;
        r_mute_val = 1'b0;
      end else if (f == 30) begin
        r_rst = 20;
      end else if (f == 40) begin
        len_l = SB - 1;
      end else if (f > 24 && $urandom_range(0, 7) == 0) begin
        k     = $urandom_range(0, 13);
        len_l = (k < 6) ? 26 + k : 33 + (k - 6);
      end else if (f > 24 && $urandom_range(0, 5) == 0) begin
        l_mute_at  = $urandom_range(0, SB - 1);
        l_mute_val = !m_mute;
      end
      drive_half(1'b0, len_l, wl_s, -1, l_mute_at, l_mute_val);
      drive_half(1'b1, SB, wr_s, r_rst, r_mute_at, r_mute_val);
    end

    // LRCK frozen: lock must drop at saturation and the pending word vanish.
    for (int i = 0; i < 100; i++) step(1'b0, 1'($urandom), 1'b0);
    repeat (3) @(negedge BCK);
    #1;
    check("expected_drained", exp_q.size(), 0);
    check("final_unlocked", 32'(LOCKED), 32'd0);
    check("final_leout", 32'(LEOUT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
